// File: rtl/rx_word_assembler.sv
// rx_word_assembler: packs a UART byte stream into WORD_BYTES-wide words and
// queues them in a small first-word-fall-through FIFO.
// Optional feature: define RX_WORD_TIMEOUT_EN to discard partial words after
// TIMEOUT_CYCLES idle clocks. When it is undefined, partial words are held.
module rx_word_assembler #(
   parameter int unsigned WORD_BYTES     = 4,
   parameter int unsigned BIG_ENDIAN     = 1,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [7:0]                        rx_byte,
   input  logic                              rx_valid,
   input  logic                              resync,
   output logic [8*WORD_BYTES-1:0]           word_out,
   output logic                              word_valid,
   input  logic                              word_ready,
   output logic [$clog2(WORD_BYTES)-1:0]     byte_count,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              overflow,
   output logic                              timeout
);

   localparam int unsigned CW = $clog2(WORD_BYTES);
   localparam int unsigned WW = 8 * WORD_BYTES;
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] LAST_SLOT = CW'(WORD_BYTES - 1);
   localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);

   // Reject illegal parameterisations at elaboration
   if (WORD_BYTES < 2 || WORD_BYTES > 8) begin : g_bad_word_bytes
      $error("rx_word_assembler: WORD_BYTES must be 2..8");
   end
   if (BIG_ENDIAN > 1) begin : g_bad_endian
      $error("rx_word_assembler: BIG_ENDIAN must be 0 or 1");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("rx_word_assembler: FIFO_DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("rx_word_assembler: TIMEOUT_CYCLES must be >= 2");
   end

   logic [CW-1:0] bc_q, bc_d;
   logic [WW-1:0] acc_q, acc_d;
   logic [CW-1:0] slot_c, pos_c;
   logic          push_c;
   logic          fire_c;

   logic [WW-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic          valid_q, valid_d;
   logic          ovf_q, ovf_d;
   logic          full_c, pop_c, wr_en_c;

`ifdef RX_WORD_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_q, idle_d;
   logic          tmo_q;

   // Idle counter: runs while a partial word is held, cleared by any byte
   always_comb begin
      fire_c = (idle_q == TW'(TIMEOUT_CYCLES)) && (bc_q != '0);
      idle_d = idle_q + TW'(1);
      if (rx_valid || (bc_q == '0) || fire_c) begin
         idle_d = '0;
      end
   end

   // Idle counter and timeout pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_q <= '0;
         tmo_q  <= 1'b0;
      end else begin
         idle_q <= idle_d;
         tmo_q  <= fire_c;
      end
   end

   assign timeout = tmo_q;
`else
   assign fire_c  = 1'b0;
   assign timeout = 1'b0;
`endif

   // Byte assembly: resync or timeout restart the word at slot 0
   always_comb begin
      acc_d  = acc_q;
      bc_d   = bc_q;
      push_c = 1'b0;
      slot_c = (resync || fire_c) ? '0 : bc_q;
      pos_c  = (BIG_ENDIAN != 0) ? (LAST_SLOT - slot_c) : slot_c;
      if (rx_valid) begin
         for (int i = 0; i < int'(WORD_BYTES); i++) begin
            if (pos_c == CW'(i)) begin
               acc_d[8*i +: 8] = rx_byte;
            end
         end
         if (slot_c == LAST_SLOT) begin
            push_c = 1'b1;
            bc_d   = '0;
         end else begin
            bc_d = slot_c + CW'(1);
         end
      end else if (resync || fire_c) begin
         bc_d = '0;
      end
   end

   // FIFO control: a full FIFO still accepts a push when it pops that cycle
   always_comb begin
      full_c  = (lvl_q == FULL_LVL);
      pop_c   = (lvl_q != '0) && word_ready;
      wr_en_c = push_c && (!full_c || pop_c);
      ovf_d   = push_c && full_c && !pop_c;
      wr_d    = wr_en_c ? (wr_q + PW'(1)) : wr_q;
      rd_d    = pop_c ? (rd_q + PW'(1)) : rd_q;
      lvl_d   = lvl_q;
      if (wr_en_c && !pop_c) begin
         lvl_d = lvl_q + LW'(1);
      end else if (!wr_en_c && pop_c) begin
         lvl_d = lvl_q - LW'(1);
      end
      valid_d = (lvl_d != '0);
   end

   // Assembler and FIFO control state
   always_ff @(posedge clk) begin
      if (rst) begin
         bc_q    <= '0;
         acc_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         lvl_q   <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         bc_q    <= bc_d;
         acc_q   <= acc_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         lvl_q   <= lvl_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   // FIFO storage; contents are don't-care while empty so no reset
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         mem_q[wr_q] <= acc_d;
      end
   end

   assign word_out   = mem_q[rd_q];
   assign word_valid = valid_q;
   assign byte_count = bc_q;
   assign fifo_level = lvl_q;
   assign overflow   = ovf_q;

endmodule
